cache_line_arbiter: RTL

Shares the single physical-memory cacheline port between the instruction-cache and data-cache miss paths that sit below the processor's I/D cache ports. Each cache issues at most one 256-bit line read (or, for the data cache, a line write-back) at a time. The arbiter grants one client, holds a registered copy of that request on the memory port until the memory responds, and returns the response to the granted client. Data-cache requests win by default, and a starvation counter guarantees instruction fetch progress.

---
 rtl/arbiter_types.sv | 15 +
 rtl/cache_line_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/arbiter_types.sv
// Shared state and owner types for the cacheline arbiter and downstream memory-side logic.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/cache_line_arbiter.sv
// Shares one memory cacheline port between the I-cache and D-cache miss paths.
// D wins by default; a starvation counter forces an I grant after STARVE_LIMIT D grants.
module cache_line_arbiter
  import arbiter_types::*;
#(
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_line_read,
  input  logic [ADDR_W-1:0] i_line_addr,
  output logic [LINE_W-1:0] i_line_rdata,
  output logic              i_line_resp,

  input  logic              d_line_read,
  input  logic              d_line_write,
  input  logic [ADDR_W-1:0] d_line_addr,
  input  logic [LINE_W-1:0] d_line_wdata,
  output logic [LINE_W-1:0] d_line_rdata,
  output logic              d_line_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned CntBits = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CntW    = (CntBits > 2) ? CntBits : 2;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic i_req, d_req, grant_i;

  assign i_req = i_line_read;
  assign d_req = d_line_read | d_line_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      starve_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_i     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = BUSY;
          grant_i = i_req && (!d_req || (starve_q == StarveMax));
          if (grant_i) begin
            owner_d     = OWN_I;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = i_line_addr;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_D;
            mem_read_d  = d_line_read;
            mem_write_d = d_line_write;
            mem_addr_d  = d_line_addr;
            if (d_line_write) begin
              mem_wdata_d = d_line_wdata;
            end
            // Count only D grants that overtook a waiting I request.
            if (i_req) begin
              starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d     = GAP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // Responses outside BUSY are stray and must not reach either client.
  always_comb begin
    i_line_resp = 1'b0;
    d_line_resp = 1'b0;
    if ((state_q == BUSY) && mem_resp) begin
      if (owner_q == OWN_I) begin
        i_line_resp = 1'b1;
      end else begin
        d_line_resp = 1'b1;
      end
    end
  end

  assign i_line_rdata = mem_rdata;
  assign d_line_rdata = mem_rdata;
  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
